// File: rtl/fb_access_arbiter_if.sv
// Purpose : bundles the frame-buffer client and BRAM-side signals of fb_access_arbiter.
// Latency : wires only; timing is defined by the arbiter that uses the slave modport.
// Backpr. : wr_req is held by the writer until wr_ack; the VGA and clear paths have no backpressure.
//
// Ports carried
//   vga_active, vga_addr, vga_pixel      VGA scan-out read path
//   wr_req, wr_addr, wr_data, wr_ack     pixel-writer request/acknowledge
//   clear_start, clear_color             full-screen clear request
//   clear_busy, clear_done               clear status
//   bram_en, bram_we, bram_addr,
//   bram_wdata, bram_rdata               single-port frame-buffer BRAM
// Modports
//   master : clients and BRAM side (drives requests and bram_rdata)
//   slave  : the arbiter

interface fb_access_arbiter_if #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 16
);
    // VGA scan-out
    logic              vga_active;
    logic [ADDR_W-1:0] vga_addr;
    logic [DATA_W-1:0] vga_pixel;

    // Pixel writer
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ack;

    // Clear sequencer control and status
    logic              clear_start;
    logic [DATA_W-1:0] clear_color;
    logic              clear_busy;
    logic              clear_done;

    // Frame-buffer BRAM
    logic              bram_en;
    logic              bram_we;
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_wdata;
    logic [DATA_W-1:0] bram_rdata;

    modport master (
        output vga_active, vga_addr,
        output wr_req, wr_addr, wr_data,
        output clear_start, clear_color,
        output bram_rdata,
        input  vga_pixel, wr_ack, clear_busy, clear_done,
        input  bram_en, bram_we, bram_addr, bram_wdata
    );

    modport slave (
        input  vga_active, vga_addr,
        input  wr_req, wr_addr, wr_data,
        input  clear_start, clear_color,
        input  bram_rdata,
        output vga_pixel, wr_ack, clear_busy, clear_done,
        output bram_en, bram_we, bram_addr, bram_wdata
    );
endinterface

// File: rtl/fb_access_arbiter.sv
// Purpose : shares one single-port frame-buffer BRAM between VGA reads, a clear sequencer and a pixel writer.
// Latency : BRAM port mux and wr_ack are combinational (same cycle); vga_pixel follows vga_addr by the BRAM's 1 cycle.
// Backpr. : wr_req waits (no ack) during active video or while clearing; the clear sequencer stalls during active video.
//
// Ports
//   clk     : pixel clock, the only clock
//   reset   : synchronous, active-high
//   bus     : fb_access_arbiter_if.slave (VGA, writer, clear control/status, BRAM signals)
// Priority : VGA read > clear sequencer > pixel writer. Nothing is written while vga_active=1.

module fb_access_arbiter #(
    parameter int ADDR_W   = 17,
    parameter int DATA_W   = 16,
    parameter int FB_DEPTH = 76800
) (
    input  logic                  clk,
    input  logic                  reset,
    fb_access_arbiter_if.slave    bus
);

    // Last frame-buffer address written by the clear sequence.
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_DEPTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] clr_addr;
    logic [ADDR_W-1:0] clr_addr_nxt;
    logic [DATA_W-1:0] clr_color;
    logic [DATA_W-1:0] clr_color_nxt;
    logic              clear_done;
    logic              clear_done_nxt;

    // Grants. Active video blocks every write; the clear sequencer
    // shadows the pixel writer for the whole CLEAR state.
    logic clr_grant;
    logic px_grant;

    assign clr_grant = (state == CLEAR) && !bus.vga_active;
    assign px_grant  = (state == IDLE)  && !bus.vga_active && bus.wr_req;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            clr_addr   <= '0;
            clr_color  <= '0;
            clear_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            clr_addr   <= clr_addr_nxt;
            clr_color  <= clr_color_nxt;
            clear_done <= clear_done_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt      = state;
        clr_addr_nxt   = clr_addr;
        clr_color_nxt  = clr_color;
        clear_done_nxt = 1'b0;

        case (state)
            IDLE: begin
                // A clear may start during active video; it simply
                // stalls until the first blanking cycle.
                if (bus.clear_start) begin
                    state_nxt     = CLEAR;
                    clr_addr_nxt  = '0;
                    clr_color_nxt = bus.clear_color;
                end
            end

            CLEAR: begin
                // clear_start is ignored here: a running clear is never restarted.
                if (clr_grant) begin
                    if (clr_addr == LAST_ADDR) begin
                        state_nxt      = IDLE;
                        clr_addr_nxt   = '0;
                        clear_done_nxt = 1'b1;
                    end else begin
                        clr_addr_nxt = clr_addr + ADDR_W'(1);
                    end
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // BRAM port mux
    // ------------------------------------------------------------------
    always_comb begin
        bus.bram_en    = 1'b0;
        bus.bram_we    = 1'b0;
        bus.bram_addr  = '0;
        bus.bram_wdata = '0;

        if (bus.vga_active) begin
            bus.bram_en   = 1'b1;
            bus.bram_addr = bus.vga_addr;
        end else if (clr_grant) begin
            bus.bram_en    = 1'b1;
            bus.bram_we    = 1'b1;
            bus.bram_addr  = clr_addr;
            bus.bram_wdata = clr_color;
        end else if (px_grant) begin
            bus.bram_en    = 1'b1;
            bus.bram_we    = 1'b1;
            bus.bram_addr  = bus.wr_addr;
            bus.bram_wdata = bus.wr_data;
        end
    end

    // The BRAM's own read register provides the one-cycle alignment
    // between the VGA address and its pixel.
    assign bus.vga_pixel  = bus.bram_rdata;
    assign bus.wr_ack     = px_grant;
    assign bus.clear_busy = (state == CLEAR);
    assign bus.clear_done = clear_done;

endmodule

// File: tb/tb_fb_access_arbiter.sv
// Purpose : self-checking bench for fb_access_arbiter with a BRAM model and a scoreboard.
// Latency : the stimulus side pushes one expected record per cycle; the monitor pops one per cycle.
// Backpr. : the writer holds wr_req until the reference model predicts the ack.

module tb_fb_access_arbiter;

    localparam int ADDR_W   = 17;
    localparam int DATA_W   = 16;
    // Reduced frame size keeps full clears with a 1-in-4 blanking pattern short.
    localparam int FB_DEPTH = 1024;

    logic clk = 1'b0;
    logic reset;
    always #20 clk = ~clk;

    fb_access_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    fb_access_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .FB_DEPTH (FB_DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ------------------------------------------------------------------
    // Environment BRAM: single port, 1-cycle read latency
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] bram_mem [FB_DEPTH] = '{default: '0};
    logic [DATA_W-1:0] bram_rdq = '0;
    assign bus.bram_rdata = bram_rdq;

    always @(posedge clk) begin
        if (bus.bram_en && int'(bus.bram_addr) < FB_DEPTH) begin
            if (bus.bram_we) bram_mem[bus.bram_addr] <= bus.bram_wdata;
            else             bram_rdq <= bram_mem[bus.bram_addr];
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    typedef struct packed {
        logic              en;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic              ack;
        logic              busy;
        logic              done;
        logic [DATA_W-1:0] pixel;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   dut_clr_wr = 0;
    int   dut_done_cnt = 0;

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, got, want);
        end
    endtask

    // Monitor: compares the DUT outputs against the oldest expectation.
    initial begin
        exp_t e;
        bit   ok;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                ok = (bus.bram_en == e.en) && (bus.bram_we == e.we) && (bus.bram_addr == e.addr) &&
                     ((e.en && !e.we) || bus.bram_wdata == e.wdata);
                checks++;
                if (!ok) begin
                    errors++;
                    $display("FAIL bram_port t=%0t got en=%b we=%b addr=%h wdata=%h want en=%b we=%b addr=%h wdata=%h",
                             $time, bus.bram_en, bus.bram_we, bus.bram_addr, bus.bram_wdata,
                             e.en, e.we, e.addr, e.wdata);
                end
                chk("wr_ack",     int'(bus.wr_ack),     int'(e.ack));
                chk("clear_busy", int'(bus.clear_busy), int'(e.busy));
                chk("clear_done", int'(bus.clear_done), int'(e.done));
                chk("vga_pixel",  int'(bus.vga_pixel),  int'(e.pixel));
                if (bus.bram_we && bus.clear_busy) dut_clr_wr++;
                if (bus.clear_done) dut_done_cnt++;
            end
        end
    end

    // ------------------------------------------------------------------
    // Reference model: a picture array plus "clearing / next pixel" bookkeeping
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] ref_mem [FB_DEPTH] = '{default: '0};
    bit                m_clearing = 1'b0;
    int                m_idx = 0;
    logic [DATA_W-1:0] m_col = '0;
    bit                m_done = 1'b0;
    logic [DATA_W-1:0] m_rd = '0;

    // Stimulus state
    bit                s_vga = 1'b0;
    int                s_vaddr = 0;
    bit                s_clr = 1'b0;
    logic [DATA_W-1:0] s_ccol = '0;
    bit                s_rst = 1'b0;
    bit                w_pend = 1'b0;
    int                w_addr = 0;
    logic [DATA_W-1:0] w_data = '0;

    // Drive one cycle of stimulus (called at posedge+1), predict, advance the model.
    task automatic step();
        exp_t e;
        reset           = s_rst;
        bus.vga_active  = s_vga;
        bus.vga_addr    = ADDR_W'(s_vaddr);
        bus.wr_req      = w_pend;
        bus.wr_addr     = ADDR_W'(w_addr);
        bus.wr_data     = w_data;
        bus.clear_start = s_clr;
        bus.clear_color = s_ccol;

        e       = '0;
        e.busy  = m_clearing;
        e.done  = m_done;
        e.pixel = m_rd;
        if (s_vga) begin
            e.en   = 1'b1;
            e.addr = ADDR_W'(s_vaddr);
        end else if (m_clearing) begin
            e.en    = 1'b1;
            e.we    = 1'b1;
            e.addr  = ADDR_W'(m_idx);
            e.wdata = m_col;
        end else if (w_pend) begin
            e.en    = 1'b1;
            e.we    = 1'b1;
            e.addr  = ADDR_W'(w_addr);
            e.wdata = w_data;
            e.ack   = 1'b1;
        end
        exp_q.push_back(e);

        if (s_vga) m_rd = ref_mem[s_vaddr];
        if (e.we) ref_mem[int'(e.addr)] = e.wdata;

        m_done = 1'b0;
        if (m_clearing) begin
            if (!s_vga) begin
                if (m_idx == FB_DEPTH - 1) begin
                    m_clearing = 1'b0;
                    m_idx      = 0;
                    m_done     = 1'b1;
                end else begin
                    m_idx++;
                end
            end
        end else if (s_clr) begin
            m_clearing = 1'b1;
            m_idx      = 0;
            m_col      = s_ccol;
        end
        if (s_rst) begin
            m_clearing = 1'b0;
            m_idx      = 0;
            m_col      = '0;
            m_done     = 1'b0;
        end
        if (e.ack) w_pend = 1'b0;
        s_clr = 1'b0;
        s_rst = 1'b0;

        @(posedge clk);
        #1;
    endtask

    task automatic post_write(input int a, input logic [DATA_W-1:0] d);
        w_pend = 1'b1;
        w_addr = a;
        w_data = d;
    endtask

    // Run until the model leaves CLEAR; vga pattern: low 1 cycle in every `period`.
    task automatic run_clear(input string name, input int period);
        int n;
        n = 0;
        while (m_clearing && n < 8 * FB_DEPTH + 16) begin
            s_vga   = (period > 1) && ((n % period) != 0);
            s_vaddr = int'($urandom % FB_DEPTH);
            step();
            n++;
        end
        if (m_clearing) chk({name, "_timeout"}, 1, 0);
        s_vga = 1'b0;
    endtask

    // Watchdog
    initial begin
        #10ms;
        $display("FAIL watchdog t=%0t simulation did not complete", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int base_wr;
        int base_done;
        int n;

        reset           = 1'b1;
        bus.vga_active  = 1'b0;
        bus.vga_addr    = '0;
        bus.wr_req      = 1'b0;
        bus.wr_addr     = '0;
        bus.wr_data     = '0;
        bus.clear_start = 1'b0;
        bus.clear_color = '0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state is compared by the monitor on the first records.
        s_rst = 1'b1;
        step();
        step();

        // Single pixel write during blanking is acked the same cycle.
        post_write('h00123, 16'hF800);
        step();
        step();

        // Write held off by 5 cycles of active video, acked on the 6th.
        post_write('h0002A, 16'h1234);
        for (int i = 0; i < 5; i++) begin
            s_vga   = 1'b1;
            s_vaddr = int'($urandom % FB_DEPTH);
            step();
        end
        s_vga = 1'b0;
        step();
        chk("wr_after_hold_pending", int'(w_pend), 0);

        // Read path: write pixel 5, read it back one cycle later.
        post_write(5, 16'hBEEF);
        step();
        s_vga   = 1'b1;
        s_vaddr = 5;
        step();
        chk("pixel_addr5", int'(bus.vga_pixel), int'(16'hBEEF));
        s_vga = 1'b0;
        step();

        // Full clear with blanking one cycle in four.
        base_wr   = dut_clr_wr;
        base_done = dut_done_cnt;
        s_ccol = 16'h07E0;
        s_clr  = 1'b1;
        step();
        run_clear("clear1", 4);
        repeat (2) step();
        chk("clear1_writes", dut_clr_wr - base_wr, FB_DEPTH);
        chk("clear1_done_pulses", dut_done_cnt - base_done, 1);
        for (int i = 0; i < 8; i++) begin
            s_vga   = 1'b1;
            s_vaddr = int'($urandom % FB_DEPTH);
            step();
        end
        s_vga = 1'b0;
        step();
        chk("pixel_after_clear", int'(bus.vga_pixel), int'(16'h07E0));

        // Write and a second clear_start during CLEAR: no ack, no restart.
        s_ccol = 16'h001F;
        s_clr  = 1'b1;
        step();
        for (int i = 0; i < 20; i++) begin
            s_vga = ($urandom % 4) == 0;
            step();
        end
        post_write('h00077, 16'hAAAA);
        s_clr  = 1'b1;
        s_ccol = 16'hFFFF;
        step();
        run_clear("clear2", 1);
        n = 0;
        while (w_pend && n < 16) begin
            step();
            n++;
        end
        chk("clear2_write_acked", int'(w_pend), 0);
        step();

        // Reset in the middle of a clear.
        s_ccol = 16'h3333;
        s_clr  = 1'b1;
        step();
        n = 0;
        while (m_idx != 1000 && n < 2 * FB_DEPTH) begin
            step();
            n++;
        end
        s_rst = 1'b1;
        step();
        chk("busy_after_rst", int'(bus.clear_busy), 0);
        chk("we_after_rst",   int'(bus.bram_we), 0);
        chk("done_after_rst", int'(bus.clear_done), 0);
        repeat (3) step();
        s_ccol = 16'h5A5A;
        s_clr  = 1'b1;
        step();
        chk("restart_addr", int'(bus.bram_addr), 0);
        chk("restart_we",   int'(bus.bram_we), 1);
        run_clear("clear3", 2);
        step();

        // Randomised traffic.
        for (int i = 0; i < 6000; i++) begin
            s_vga   = ($urandom % 100) < 50;
            s_vaddr = int'($urandom % FB_DEPTH);
            if (!w_pend && ($urandom % 3) == 0)
                post_write(int'($urandom % FB_DEPTH), DATA_W'($urandom));
            if (($urandom % 400) == 0) begin
                s_clr  = 1'b1;
                s_ccol = DATA_W'($urandom);
            end
            if (($urandom % 2500) == 0) s_rst = 1'b1;
            step();
        end

        s_vga = 1'b0;
        repeat (3) step();
        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
